cnnip_dpram: RTL



---
 rtl/cnnip_dpram.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cnnip_dpram.sv
// cnnip_dpram: true-dual-port byte-writable block RAM with a READ_LATENCY-deep read pipeline.
// Define CNNIP_MEM_BYPASS_EN for write-first forwarding across ports; default is read-first.
module cnnip_dpram #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1 << ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = 2,
    localparam int unsigned NB          = ((DATA_WIDTH - 1) >> 3) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic [NB-1:0]         a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic [NB-1:0]         b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]            en;
    logic [NB-1:0]         we   [2];
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] din  [2];

    assign en      = {b_en, a_en};
    assign we[0]   = a_we;
    assign we[1]   = b_we;
    assign addr[0] = a_addr;
    assign addr[1] = b_addr;
    assign din[0]  = a_din;
    assign din[1]  = b_din;

    logic [1:0]            in_rng;
    logic [1:0]            wr;
    logic [1:0]            rd;
    logic                  same_addr;
    logic                  dual_wr;
    logic [DATA_WIDTH-1:0] mask  [2];
    logic [DATA_WIDTH-1:0] old   [2];
    logic [DATA_WIDTH-1:0] rword [2];
    logic [DATA_WIDTH-1:0] a_wmask;
    logic [DATA_WIDTH-1:0] a_wdata;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = 32'(addr[p]) < DEPTH;
            wr[p]     = !rst && en[p] && (we[p] != '0) && in_rng[p];
            rd[p]     = !rst && en[p] && (we[p] == '0);
            mask[p]   = '0;
            for (int b = 0; b < int'(DATA_WIDTH); b++) begin
                mask[p][b] = we[p][b / 8];
            end
            old[p]    = in_rng[p] ? mem_q[addr[p]] : '0;
        end
        same_addr = addr[0] == addr[1];
        // A same-address double write is folded into a single port-A write, A winning shared lanes.
        dual_wr   = wr[0] && wr[1] && same_addr;
        a_wmask   = dual_wr ? (mask[0] | mask[1]) : mask[0];
        a_wdata   = dual_wr ? ((din[0] & mask[0]) | (din[1] & ~mask[0])) : din[0];
`ifdef CNNIP_MEM_BYPASS_EN
        for (int p = 0; p < 2; p++) begin
            rword[p] = old[p];
            if (rd[p] && wr[1-p] && same_addr) begin
                rword[p] = (old[p] & ~mask[1-p]) | (din[1-p] & mask[1-p]);
            end
        end
`else
        for (int p = 0; p < 2; p++) begin
            rword[p] = old[p];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr[0]) begin
            mem_q[addr[0]] <= (old[0] & ~a_wmask) | (a_wdata & a_wmask);
        end
        if (wr[1] && !dual_wr) begin
            mem_q[addr[1]] <= (old[1] & ~mask[1]) | (din[1] & mask[1]);
        end
    end

    // Every stage holds its word until a new valid passes, so the last stage doubles as dout.
    logic [READ_LATENCY-1:0] vld_q  [2];
    logic [DATA_WIDTH-1:0]   pipe_q [2][READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
                for (int k = 0; k < int'(READ_LATENCY); k++) begin
                    pipe_q[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p][0] <= rd[p];
                if (rd[p]) begin
                    pipe_q[p][0] <= rword[p];
                end
                for (int k = 1; k < int'(READ_LATENCY); k++) begin
                    vld_q[p][k] <= vld_q[p][k-1];
                    if (vld_q[p][k-1]) begin
                        pipe_q[p][k] <= pipe_q[p][k-1];
                    end
                end
            end
        end
    end

    assign a_dout  = pipe_q[0][READ_LATENCY-1];
    assign a_valid = vld_q[0][READ_LATENCY-1];
    assign b_dout  = pipe_q[1][READ_LATENCY-1];
    assign b_valid = vld_q[1][READ_LATENCY-1];

endmodule
